// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan driver.
//   scan_state_e : scan FSM states (GUARD blank slot, SHOW digit lit)
//   SEG_OFF      : all segments off (active-low)
//   SEG_DASH     : centre bar only, shown for codes 10..15
//   SEG_D0..D9   : decimal digit patterns {g,f,e,d,c,b,a}, active-low
package seg7_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [6:0] SEG_D0 = 7'h40;
  localparam logic [6:0] SEG_D1 = 7'h79;
  localparam logic [6:0] SEG_D2 = 7'h24;
  localparam logic [6:0] SEG_D3 = 7'h30;
  localparam logic [6:0] SEG_D4 = 7'h19;
  localparam logic [6:0] SEG_D5 = 7'h12;
  localparam logic [6:0] SEG_D6 = 7'h02;
  localparam logic [6:0] SEG_D7 = 7'h78;
  localparam logic [6:0] SEG_D8 = 7'h00;
  localparam logic [6:0] SEG_D9 = 7'h10;

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD digit to common-anode 7-segment decode.
// Ports:
//   bcd_i [3:0] : BCD code; 10..15 are invalid and decode to a dash
//   seg_o [6:0] : segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_D0;
      4'd1:    seg_o = SEG_D1;
      4'd2:    seg_o = SEG_D2;
      4'd3:    seg_o = SEG_D3;
      4'd4:    seg_o = SEG_D4;
      4'd5:    seg_o = SEG_D5;
      4'd6:    seg_o = SEG_D6;
      4'd7:    seg_o = SEG_D7;
      4'd8:    seg_o = SEG_D8;
      4'd9:    seg_o = SEG_D9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment display driver.
// Captures packed BCD digits into a shadow register on load and scans them
// one digit at a time, with a one-cycle all-off guard slot between digits,
// optional leading-zero blanking and a dash for invalid codes.
// Parameters:
//   NUM_DIGITS  : digits scanned (2..8)
//   REFRESH_DIV : clk cycles each digit is lit (>=2)
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   load     : 1-cycle strobe, captures bcd_i into the shadow register
//   bcd_i    : packed BCD, digit 0 in bits [3:0]
//   blank_en : 1 = blank leading zeros (digit 0 is never blanked)
//   an_o     : digit enables, one-hot active-low, all-ones = all off
//   seg_o    : segments {g,f,e,d,c,b,a}, active-low
//   frame_o  : 1-cycle pulse when the scan wraps back to digit 0
// Build option SEG7_DP_EN adds dp_i (per-digit decimal point, captured with
// load) and dp_o (active-low decimal point of the lit digit).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic                    blank_en,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [6:0]              seg_o,
  output logic                    frame_o
`ifdef SEG7_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic                    dp_o
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  scan_state_e             state_q;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    first_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    frame_q;

  logic [3:0]              digit_sel;
  logic [6:0]              dec_seg;
  logic [6:0]              show_seg;
  logic [NUM_DIGITS-1:0]   an_show;
  logic [NUM_DIGITS-1:0]   nz_from;
  logic                    nz_acc;
  logic                    blank_digit;

  assign shadow_d = load ? bcd_i : shadow_q;

  // Index of the digit entered on the next GUARD exit; the first exit after
  // reset stays on digit 0 instead of advancing.
  always_comb begin
    idx_d = '0;
    if (!first_q && (idx_q != IDX_W'(NUM_DIGITS - 1))) begin
      idx_d = idx_q + 1'b1;
    end
  end

  assign digit_sel = shadow_q[{idx_d, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd_i (digit_sel),
    .seg_o (dec_seg)
  );

  // nz_from[k] is set when digit k or any higher digit is non-zero; invalid
  // codes are non-zero and therefore stop the blanking run.
  always_comb begin
    nz_acc  = 1'b0;
    nz_from = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      nz_acc = nz_acc | (shadow_q[4*(NUM_DIGITS-1-k) +: 4] != 4'd0);
      nz_from[NUM_DIGITS-1-k] = nz_acc;
    end
  end

  assign blank_digit = blank_en && (idx_d != '0) && !nz_from[idx_d];
  assign show_seg    = blank_digit ? SEG_OFF : dec_seg;
  assign an_show     = ~(NUM_DIGITS'(1) << idx_d);

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0] dp_shadow_q;
  logic                  dp_q;
`endif

  // The lit pattern is latched on GUARD->SHOW and held for the whole slot,
  // so a load landing mid-slot only appears on that digit's next slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= GUARD;
      shadow_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b1;
      an_q     <= '1;
      seg_q    <= SEG_OFF;
      frame_q  <= 1'b0;
`ifdef SEG7_DP_EN
      dp_shadow_q <= '0;
      dp_q        <= 1'b1;
`endif
    end else begin
      shadow_q <= shadow_d;
      frame_q  <= 1'b0;
`ifdef SEG7_DP_EN
      if (load) begin
        dp_shadow_q <= dp_i;
      end
`endif
      case (state_q)
        GUARD: begin
          state_q <= SHOW;
          idx_q   <= idx_d;
          first_q <= 1'b0;
          cnt_q   <= '0;
          an_q    <= an_show;
          seg_q   <= show_seg;
          frame_q <= !first_q && (idx_d == '0);
`ifdef SEG7_DP_EN
          dp_q    <= ~dp_shadow_q[idx_d];
`endif
        end
        SHOW: begin
          if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            state_q <= GUARD;
            cnt_q   <= '0;
            an_q    <= '1;
            seg_q   <= SEG_OFF;
`ifdef SEG7_DP_EN
            dp_q    <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= GUARD;
      endcase
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign frame_o = frame_q;
`ifdef SEG7_DP_EN
  assign dp_o    = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver (4 digits,
// 4 cycles per digit). Expected digit slots are queued as loads are issued
// and popped by a negedge monitor at the start of each lit slot.
module tb_seg7_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        blank_en = 1'b0;
  logic [15:0] bcd_i = '0;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        frame_o;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;
  } slot_t;

  slot_t       exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [15:0] cur_bcd = '0;
  logic        cur_blank = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .bcd_i    (bcd_i),
    .blank_en (blank_en),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .frame_o  (frame_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input logic blank, input int k);
    logic [15:0] upper;
    logic [3:0]  d;
    upper = v >> (4 * k);
    d     = upper[3:0];
    if (blank && k > 0 && upper == 16'h0) return 7'h7F;
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // One frame of expectations; digit 3 may come from a different value when
  // a load lands between digit 0 and digit 3 of the frame.
  task automatic push_frame(input logic [15:0] v_low, input logic [15:0] v_d3,
                            input logic blank, input logic frame0);
    slot_t s;
    for (int k = 0; k < 4; k++) begin
      s.an    = ~(4'b0001 << k);
      s.seg   = ref_seg((k == 3) ? v_d3 : v_low, blank, k);
      s.frame = (k == 0) && frame0;
      exp_q.push_back(s);
    end
  endtask

  task automatic wait_an(input logic [3:0] v);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (an_o === v) return;
    end
    check("wait_an_timeout", {28'h0, an_o}, {28'h0, v});
  endtask

  task automatic run_frame(input logic [15:0] v, input logic b);
    wait_an(4'h7);
    bcd_i    = v;
    blank_en = b;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    wait_an(4'hF);
    push_frame(v, v, b, 1'b1);
    cur_bcd   = v;
    cur_blank = b;
  endtask

  // Monitor: slot/guard lengths, in-slot stability, frame period, scoreboard.
  int          glen = 1;
  int          slen = 0;
  int          since = -1;
  logic        in_slot = 1'b0;
  logic [6:0]  slot_seg;
  logic [3:0]  slot_an;
  slot_t       e;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_an", {28'h0, an_o}, 32'hF);
      check("rst_seg", {25'h0, seg_o}, 32'h7F);
      check("rst_frame", {31'h0, frame_o}, 32'h0);
      in_slot = 1'b0;
      glen    = 1;
      slen    = 0;
      since   = -1;
    end else begin
      if (since >= 0) since++;
      if (frame_o) begin
        if (since >= 0) check("frame_period", since, 20);
        since = 0;
      end
      if (an_o === 4'hF) begin
        check("guard_seg", {25'h0, seg_o}, 32'h7F);
        check("guard_frame", {31'h0, frame_o}, 32'h0);
        if (in_slot) begin
          check("slot_len", slen, RD);
          in_slot = 1'b0;
          glen    = 0;
        end
        glen++;
      end else begin
        if (!in_slot) begin
          check("guard_len", glen, 1);
          in_slot  = 1'b1;
          slen     = 0;
          slot_seg = seg_o;
          slot_an  = an_o;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("slot_an", {28'h0, an_o}, {28'h0, e.an});
            check("slot_seg", {25'h0, seg_o}, {25'h0, e.seg});
            check("slot_frame", {31'h0, frame_o}, {31'h0, e.frame});
          end
        end else begin
          check("hold_seg", {25'h0, seg_o}, {25'h0, slot_seg});
          check("hold_an", {28'h0, an_o}, {28'h0, slot_an});
          check("hold_frame", {31'h0, frame_o}, 32'h0);
        end
        slen++;
      end
    end
  end

  initial begin
    // Power-on reset held for three cycles; first frame shows cleared shadow.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    push_frame(16'h0000, 16'h0000, 1'b0, 1'b0);
    #1 rst = 1'b1;

    run_frame(16'h1234, 1'b0);
    run_frame(16'h0007, 1'b1);
    run_frame(16'h0000, 1'b1);
    run_frame(16'h0A05, 1'b1);
    run_frame(16'h9876, 1'b0);
    run_frame(16'h0F00, 1'b1);

    // Load mid-slot of digit 2: digit 2 keeps the old pattern, digit 3 of
    // the same frame already shows the new value.
    wait_an(4'h7);
    wait_an(4'hF);
    push_frame(cur_bcd, 16'h4321, cur_blank, 1'b1);
    wait_an(4'hB);
    @(negedge clk);
    bcd_i = 16'h4321;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    cur_bcd = 16'h4321;
    wait_an(4'h7);
    wait_an(4'hF);
    push_frame(cur_bcd, cur_bcd, cur_blank, 1'b1);

    // Asynchronous reset in the middle of digit 3's slot.
    wait_an(4'h7);
    @(negedge clk);
    #1 rst = 1'b0;
    blank_en = 1'b0;
    #1;
    check("async_rst_an", {28'h0, an_o}, 32'hF);
    check("async_rst_seg", {25'h0, seg_o}, 32'h7F);
    check("async_rst_frame", {31'h0, frame_o}, 32'h0);
    check("rst_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    push_frame(16'h0000, 16'h0000, 1'b0, 1'b0);
    #1 rst = 1'b1;

    wait_an(4'h7);
    wait_an(4'hF);
    push_frame(16'h0000, 16'h0000, 1'b0, 1'b1);
    wait_an(4'h7);
    wait_an(4'hF);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
